vc_credit_tracker: RTL and testbench

Per-virtual-channel credit counter bank in the NoC master unit. It sits directly downstream of the registered binary-to-one-hot VC selector. It gates flit injection so that a flit on a VC is accepted only while that VC holds a credit for the downstream router buffer. Returned credits replenish the counters, and an init sequencer loads the full credit budget after reset or flush.

---
 rtl/vc_credit_tracker_if.sv | 27 ++
 rtl/vc_credit_tracker.sv | 135 +++++++++++++
 tb/tb_vc_credit_tracker.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_credit_tracker_if.sv
// Flit-injection and credit-return bundle between the NoC master unit and its credit tracker.
// The master drives VC select, flit offer, credit returns and flush; the slave reports status.
interface vc_credit_tracker_if #(
    parameter int unsigned VIRTUAL_CH_NUM = 8
);
    logic [VIRTUAL_CH_NUM-1:0] vc_onehot;
    logic                      flit_valid;
    logic                      flit_ready;
    logic                      credit_ret_valid;
    logic [VIRTUAL_CH_NUM-1:0] credit_ret_vc;
    logic                      flush;
    logic [VIRTUAL_CH_NUM-1:0] credit_avail;
    logic [VIRTUAL_CH_NUM-1:0] vc_idle;
    logic                      init_done;
    logic                      err_overflow;
    logic                      err_illegal_vc;

    modport master (
        output vc_onehot, flit_valid, credit_ret_valid, credit_ret_vc, flush,
        input  flit_ready, credit_avail, vc_idle, init_done, err_overflow, err_illegal_vc
    );

    modport slave (
        input  vc_onehot, flit_valid, credit_ret_valid, credit_ret_vc, flush,
        output flit_ready, credit_avail, vc_idle, init_done, err_overflow, err_illegal_vc
    );
endinterface

// File: rtl/vc_credit_tracker.sv
// Per-VC credit counter bank: gates flit injection on available downstream credit,
// replenishes on credit return, and loads the full budget one VC per cycle after reset/flush.
module vc_credit_tracker #(
    parameter int unsigned VIRTUAL_CH_NUM = 8,
    parameter int unsigned CREDIT_WIDTH   = 4,
    parameter int unsigned MAX_CREDIT     = 8
) (
    input logic                   sclk,
    input logic                   s_rst_n,
    vc_credit_tracker_if.slave    bus
);
    localparam int unsigned IDX_W = (VIRTUAL_CH_NUM > 1) ? $clog2(VIRTUAL_CH_NUM) : 1;
    localparam logic [CREDIT_WIDTH-1:0] MaxCnt = CREDIT_WIDTH'(MAX_CREDIT);
    localparam logic [IDX_W-1:0]        LastIdx = IDX_W'(VIRTUAL_CH_NUM - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      init_done;

    logic [CREDIT_WIDTH-1:0]   cnt_q [VIRTUAL_CH_NUM];
    logic [CREDIT_WIDTH-1:0]   cnt_d [VIRTUAL_CH_NUM];
    logic [VIRTUAL_CH_NUM-1:0] avail_q, avail_d;
    logic [VIRTUAL_CH_NUM-1:0] idle_q, idle_d;
    logic                      ovf_q, ill_q;
    logic                      ovf_hit, ill_hit;

    logic                      flit_ok, ret_ok, send;
    logic [VIRTUAL_CH_NUM-1:0] send_vec, ret_vec;

    function automatic logic onehot_ok(input logic [VIRTUAL_CH_NUM-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic multi_hot(input logic [VIRTUAL_CH_NUM-1:0] v);
        return (v != '0) && !onehot_ok(v);
    endfunction

    // FSM: state register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= StInit;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (bus.flush) begin
            state_d = StInit;
            idx_d   = '0;
        end else if (state_q == StInit) begin
            if (idx_q == LastIdx) begin
                state_d = StRun;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        init_done = (state_q == StRun);
    end

    assign flit_ok  = onehot_ok(bus.vc_onehot);
    assign send     = init_done & bus.flit_valid & flit_ok & (|(bus.vc_onehot & avail_q));
    assign ret_ok   = init_done & bus.credit_ret_valid & onehot_ok(bus.credit_ret_vc);
    assign send_vec = {VIRTUAL_CH_NUM{send}} & bus.vc_onehot;
    assign ret_vec  = {VIRTUAL_CH_NUM{ret_ok}} & bus.credit_ret_vc;
    assign ill_hit  = (bus.flit_valid & multi_hot(bus.vc_onehot)) |
                      (bus.credit_ret_valid & multi_hot(bus.credit_ret_vc));

    always_comb begin
        cnt_d   = cnt_q;
        ovf_hit = 1'b0;
        if (bus.flush) begin
            for (int i = 0; i < VIRTUAL_CH_NUM; i++) cnt_d[i] = '0;
        end else if (state_q == StInit) begin
            cnt_d[idx_q] = MaxCnt;
        end else begin
            for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
                // Same-VC send and return cancel out.
                if (send_vec[i] && !ret_vec[i]) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else if (ret_vec[i] && !send_vec[i]) begin
                    if (cnt_q[i] == MaxCnt) begin
                        ovf_hit = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Status flags track the post-update counters so they carry no extra lag.
    always_comb begin
        avail_d = '0;
        idle_d  = '0;
        for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
            avail_d[i] = (cnt_d[i] != '0);
            idle_d[i]  = (cnt_d[i] == MaxCnt);
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < VIRTUAL_CH_NUM; i++) cnt_q[i] <= '0;
            avail_q <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            avail_q <= avail_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_q | ovf_hit;
            ill_q   <= ill_q | ill_hit;
        end
    end

    assign bus.flit_ready     = send;
    assign bus.credit_avail   = avail_q;
    assign bus.vc_idle        = idle_q;
    assign bus.init_done      = init_done;
    assign bus.err_overflow   = ovf_q;
    assign bus.err_illegal_vc = ill_q;
endmodule

// File: tb/tb_vc_credit_tracker.sv
// Scoreboard bench for vc_credit_tracker: a reference model pushes expected snapshots per cycle
// while the observed snapshots are queued alongside; each scenario task drains and compares them.
module tb_vc_credit_tracker;
    localparam int unsigned NVC  = 8;
    localparam int          MAXC = 8;

    typedef struct packed {
        logic       ready;
        logic [7:0] avail;
        logic [7:0] idle;
        logic       init;
        logic       ovf;
        logic       ill;
    } snap_t;

    logic sclk;
    logic s_rst_n;

    vc_credit_tracker_if #(.VIRTUAL_CH_NUM(NVC)) bus ();

    vc_credit_tracker #(
        .VIRTUAL_CH_NUM(NVC),
        .CREDIT_WIDTH  (4),
        .MAX_CREDIT    (MAXC)
    ) dut (
        .sclk   (sclk),
        .s_rst_n(s_rst_n),
        .bus    (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];

    // Reference model state
    int         mcnt [NVC];
    bit         minit;
    int         midx;
    bit         movf, mill;
    logic [7:0] mavail, midle;

    task automatic model_reset();
        for (int i = 0; i < NVC; i++) mcnt[i] = 0;
        minit = 0; midx = 0; movf = 0; mill = 0; mavail = '0; midle = '0;
    endtask

    function automatic logic model_ready(input logic fv, input logic [7:0] vc);
        return minit && fv && ($countones(vc) == 1) && ((vc & mavail) != 0);
    endfunction

    task automatic model_step(input logic fv, input logic [7:0] vc, input logic rv,
                              input logic [7:0] rvc, input logic fl, input logic rdy);
        if ((fv && $countones(vc) > 1) || (rv && $countones(rvc) > 1)) mill = 1;
        if (fl) begin
            for (int i = 0; i < NVC; i++) mcnt[i] = 0;
            minit = 0; midx = 0;
        end else if (!minit) begin
            mcnt[midx] = MAXC;
            if (midx == NVC - 1) minit = 1;
            else midx++;
        end else begin
            for (int i = 0; i < NVC; i++) begin
                bit s, r;
                s = rdy && vc[i];
                r = rv && ($countones(rvc) == 1) && rvc[i];
                if (s && !r) mcnt[i]--;
                else if (r && !s) begin
                    if (mcnt[i] == MAXC) movf = 1;
                    else mcnt[i]++;
                end
            end
        end
        for (int i = 0; i < NVC; i++) begin
            mavail[i] = (mcnt[i] != 0);
            midle[i]  = (mcnt[i] == MAXC);
        end
    endtask

    // One clock of stimulus: expected snapshot from the model, observed snapshot from the DUT.
    task automatic drive_cycle(input logic fv, input logic [7:0] vc, input logic rv,
                               input logic [7:0] rvc, input logic fl);
        snap_t e, o;
        bus.flit_valid = fv; bus.vc_onehot = vc;
        bus.credit_ret_valid = rv; bus.credit_ret_vc = rvc; bus.flush = fl;
        #1;
        e.ready = model_ready(fv, vc);
        o.ready = bus.flit_ready;
        model_step(fv, vc, rv, rvc, fl, e.ready);
        e.avail = mavail; e.idle = midle; e.init = minit; e.ovf = movf; e.ill = mill;
        @(posedge sclk);
        #1;
        o.avail = bus.credit_avail; o.idle = bus.vc_idle; o.init = bus.init_done;
        o.ovf = bus.err_overflow; o.ill = bus.err_illegal_vc;
        exp_q.push_back(e);
        obs_q.push_back(o);
        bus.flit_valid = 0; bus.vc_onehot = '0;
        bus.credit_ret_valid = 0; bus.credit_ret_vc = '0; bus.flush = 0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        int k = 0;
        s_rst_n = 0;
        bus.flit_valid = 0; bus.vc_onehot = '0;
        bus.credit_ret_valid = 0; bus.credit_ret_vc = '0; bus.flush = 0;
        model_reset();
        repeat (3) @(posedge sclk);
        #1;
        n_cmp++;
        if ({bus.init_done, bus.credit_avail, bus.vc_idle, bus.err_overflow, bus.err_illegal_vc}
            !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got init=%b avail=%h idle=%h ovf=%b ill=%b want all 0",
                     bus.init_done, bus.credit_avail, bus.vc_idle, bus.err_overflow,
                     bus.err_illegal_vc);
        end
        s_rst_n = 1;
        repeat (NVC) drive_cycle(0, 8'h00, 0, 8'h00, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_init[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        n_cmp++;
        if ({bus.init_done, bus.credit_avail, bus.vc_idle} !== {1'b1, 8'hFF, 8'hFF}) begin
            n_bad++;
            $display("FAIL init_done_state: got init=%b avail=%h idle=%h want 1/ff/ff",
                     bus.init_done, bus.credit_avail, bus.vc_idle);
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        int k = 0;
        repeat (MAXC + 1) drive_cycle(1, 8'h04, 0, 8'h00, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        n_cmp++;
        if ({bus.credit_avail, bus.vc_idle} !== {8'hFB, 8'hFB}) begin
            n_bad++;
            $display("FAIL drained_vc2: got avail=%h idle=%h want fb/fb",
                     bus.credit_avail, bus.vc_idle);
        end
    endtask

    task automatic test_return();
        snap_t e, o;
        int k = 0;
        drive_cycle(0, 8'h00, 1, 8'h04, 0);
        drive_cycle(1, 8'h04, 0, 8'h00, 0);
        drive_cycle(1, 8'h04, 0, 8'h00, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL return_resend[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_flush();
        snap_t e, o;
        int k = 0;
        drive_cycle(0, 8'h00, 0, 8'h00, 1);
        // Returns on VC0 and VC7 throughout INIT must all be dropped.
        for (int i = 0; i < NVC; i++) drive_cycle(0, 8'h00, 1, (i % 2 == 0) ? 8'h01 : 8'h80, 0);
        n_cmp++;
        if ({bus.init_done, bus.credit_avail, bus.vc_idle, bus.err_overflow} !==
            {1'b1, 8'hFF, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL flush_reinit: got init=%b avail=%h idle=%h ovf=%b want 1/ff/ff/0",
                     bus.init_done, bus.credit_avail, bus.vc_idle, bus.err_overflow);
        end
        drive_cycle(0, 8'h00, 0, 8'h00, 1);
        repeat (3) drive_cycle(0, 8'h00, 0, 8'h00, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL flush_seq[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        // Asynchronous reset mid-INIT, away from any clock edge.
        #2;
        s_rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.init_done, bus.credit_avail, bus.vc_idle} !== 17'h0) begin
            n_bad++;
            $display("FAIL async_reset_mid_init: got init=%b avail=%h idle=%h want all 0",
                     bus.init_done, bus.credit_avail, bus.vc_idle);
        end
        @(posedge sclk);
        #1;
        s_rst_n = 1;
        k = 0;
        repeat (NVC) drive_cycle(0, 8'h00, 0, 8'h00, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reinit_after_reset[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_simultaneous();
        snap_t e, o;
        int k = 0;
        repeat (5) drive_cycle(1, 8'h20, 0, 8'h00, 0);
        drive_cycle(1, 8'h20, 1, 8'h20, 0);
        repeat (4) drive_cycle(1, 8'h20, 0, 8'h00, 0);
        drive_cycle(1, 8'h02, 1, 8'h01, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL simultaneous[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        n_cmp++;
        if ({bus.err_overflow, bus.credit_avail, bus.vc_idle} !== {1'b1, 8'hDF, 8'hDD}) begin
            n_bad++;
            $display("FAIL overflow_vc0: got ovf=%b avail=%h idle=%h want 1/df/dd",
                     bus.err_overflow, bus.credit_avail, bus.vc_idle);
        end
    endtask

    task automatic test_illegal();
        snap_t e, o;
        int k = 0;
        drive_cycle(1, 8'h00, 0, 8'h00, 0);
        drive_cycle(1, 8'h06, 0, 8'h00, 0);
        drive_cycle(0, 8'h00, 1, 8'h06, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL illegal_vc[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        n_cmp++;
        if ({bus.err_illegal_vc, bus.vc_idle} !== {1'b1, 8'hDD}) begin
            n_bad++;
            $display("FAIL illegal_sticky: got ill=%b idle=%h want 1/dd",
                     bus.err_illegal_vc, bus.vc_idle);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_return();
        test_flush();
        test_simultaneous();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
